// File: rtl/rsa_modexp_ladder_pkg.sv
// rsa_modexp_ladder_pkg: shared FSM states and latency helper for the modexp ladder
package rsa_modexp_ladder_pkg;
   typedef enum logic [2:0] {IDLE, CHECK, LADDER_A, LADDER_B, FINISH} state_t;
   function automatic int modexp_latency(int width, int exp_w);
      return 2 * exp_w * (width + 1) + 2;
   endfunction
endpackage

// File: rtl/rsa_modexp_ladder_if.sv
// rsa_modexp_ladder_if: request/response bundle between host and modexp engine
interface rsa_modexp_ladder_if #(parameter int WIDTH = 128, parameter int EXP_W = 128);
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] message;
   logic [WIDTH-1:0] modulus;
   logic [EXP_W-1:0] exponent;
   logic             busy;
   logic             done;
   logic             error;
   logic [WIDTH-1:0] result;
   logic             result_valid;
   modport master (output start, abort, message, modulus, exponent,
                   input  busy, done, error, result, result_valid);
   modport slave  (input  start, abort, message, modulus, exponent,
                   output busy, done, error, result, result_valid);
endinterface

// File: rtl/rsa_modexp_ladder_modmul.sv
// rsa_modmul_serial: MSB-first interleaved modular multiplier, 1 load + WIDTH step cycles
module rsa_modmul_serial #(parameter int WIDTH = 128) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH + 1);
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d, acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [WIDTH+1:0] dbl, red, sum, nxt, nx;
   always_comb begin
      nx  = {2'b00, n_q};
      dbl = {1'b0, acc_q, 1'b0};
      red = dbl >= nx ? dbl - nx : dbl;
      sum = red + (b_q[WIDTH-1] ? {2'b00, a_q} : '0);
      nxt = sum >= nx ? sum - nx : sum;
      a_d = a_q;
      b_d = b_q;
      n_d = n_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      busy_d = busy_q;
      if (clear || (busy_q && cnt_q == CW'(1))) begin
         // the final step's product is consumed combinationally, so wipe everything here
         a_d = '0;
         b_d = '0;
         n_d = '0;
         acc_d = '0;
         cnt_d = '0;
         busy_d = 1'b0;
      end else if (busy_q) begin
         acc_d = nxt[WIDTH-1:0];
         b_d = b_q << 1;
         cnt_d = cnt_q - 1'b1;
      end else if (start) begin
         a_d = a;
         b_d = b;
         n_d = n;
         acc_d = '0;
         cnt_d = CW'(WIDTH);
         busy_d = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
         n_q <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         busy_q <= 1'b0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
         n_q <= n_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         busy_q <= busy_d;
      end
   end
   assign busy = busy_q;
   assign done = busy_q && cnt_q == CW'(1);
   assign product = nxt[WIDTH-1:0];
endmodule

// File: rtl/rsa_modexp_ladder.sv
// rsa_modexp_ladder: constant-time Montgomery-ladder modular exponentiation with abort and zeroization
module rsa_modexp_ladder
   import rsa_modexp_ladder_pkg::*;
#(
   parameter int WIDTH = 128,
   parameter int EXP_W = 128
) (
   input logic clk,
   input logic rst,
   rsa_modexp_ladder_if.slave bus
);
   localparam int CW = $clog2(EXP_W) > 0 ? $clog2(EXP_W) : 1;
   state_t           state_q, state_d;
   logic             busy_q, busy_d, done_q, done_d, error_q, error_d, rv_q, rv_d;
   logic [WIDTH-1:0] result_q, result_d, msg_q, msg_d, mod_q, mod_d, r0_q, r0_d, r1_q, r1_d;
   logic [EXP_W-1:0] exp_q, exp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bit_v, mm_start, mm_clear, mm_busy, mm_done;
   logic [WIDTH-1:0] mm_a, mm_b, mm_p;
   assign bit_v = exp_q[EXP_W-1];
   assign mm_a = state_q == LADDER_B ? (bit_v ? r1_q : r0_q) : r0_q;
   assign mm_b = state_q == LADDER_B ? (bit_v ? r1_q : r0_q) : r1_q;
   assign mm_start = (state_q == LADDER_A || state_q == LADDER_B) && !mm_busy && !bus.abort;
   assign mm_clear = bus.abort || state_q == FINISH;
   rsa_modmul_serial #(.WIDTH(WIDTH)) u_mm (
      .clk(clk), .rst(rst), .clear(mm_clear), .start(mm_start),
      .a(mm_a), .b(mm_b), .n(mod_q),
      .busy(mm_busy), .done(mm_done), .product(mm_p)
   );
   always_comb begin
      state_d = state_q;
      busy_d = busy_q;
      done_d = 1'b0;
      error_d = error_q;
      rv_d = rv_q;
      result_d = result_q;
      msg_d = msg_q;
      mod_d = mod_q;
      exp_d = exp_q;
      r0_d = r0_q;
      r1_d = r1_q;
      cnt_d = cnt_q;
      case (state_q)
         IDLE: if (bus.start) begin
            msg_d = bus.message;
            mod_d = bus.modulus;
            exp_d = bus.exponent;
            busy_d = 1'b1;
            error_d = 1'b0;
            rv_d = 1'b0;
            result_d = '0;
            state_d = CHECK;
         end
         CHECK: if (mod_q < WIDTH'(2) || msg_q >= mod_q) begin
            error_d = 1'b1;
            state_d = FINISH;
         end else begin
            r0_d = WIDTH'(1);
            r1_d = msg_q;
            cnt_d = CW'(EXP_W - 1);
            state_d = LADDER_A;
         end
         LADDER_A: if (mm_done) begin
            r0_d = bit_v ? mm_p : r0_q;
            r1_d = bit_v ? r1_q : mm_p;
            state_d = LADDER_B;
         end
         LADDER_B: if (mm_done) begin
            r0_d = bit_v ? r0_q : mm_p;
            r1_d = bit_v ? mm_p : r1_q;
            exp_d = exp_q << 1;
            cnt_d = cnt_q - 1'b1;
            state_d = cnt_q == '0 ? FINISH : LADDER_A;
         end
         FINISH: begin
            done_d = 1'b1;
            busy_d = 1'b0;
            rv_d = !error_q;
            result_d = error_q ? '0 : r0_q;
            msg_d = '0;
            mod_d = '0;
            exp_d = '0;
            r0_d = '0;
            r1_d = '0;
            cnt_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // abort overrides everything, including a simultaneous start in IDLE
      if (bus.abort) begin
         state_d = IDLE;
         busy_d = 1'b0;
         done_d = 1'b0;
         error_d = 1'b0;
         rv_d = 1'b0;
         result_d = '0;
         msg_d = '0;
         mod_d = '0;
         exp_d = '0;
         r0_d = '0;
         r1_d = '0;
         cnt_d = '0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         error_q <= 1'b0;
         rv_q <= 1'b0;
         result_q <= '0;
         msg_q <= '0;
         mod_q <= '0;
         exp_q <= '0;
         r0_q <= '0;
         r1_q <= '0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         busy_q <= busy_d;
         done_q <= done_d;
         error_q <= error_d;
         rv_q <= rv_d;
         result_q <= result_d;
         msg_q <= msg_d;
         mod_q <= mod_d;
         exp_q <= exp_d;
         r0_q <= r0_d;
         r1_q <= r1_d;
         cnt_q <= cnt_d;
      end
   end
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.error = error_q;
   assign bus.result = result_q;
   assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_rsa_modexp_ladder.sv
// tb_rsa_modexp_ladder: scoreboard bench for the 8-bit modexp ladder against a square-and-multiply model
module tb_rsa_modexp_ladder;
   import rsa_modexp_ladder_pkg::*;
   localparam int LAT = modexp_latency(8, 8);
   typedef struct {int res; bit err; longint cyc;} exp_t;
   logic   clk = 1'b0;
   logic   rst = 1'b1;
   longint cyc = 0;
   int     checks = 0, failures = 0, n_done = 0, n_want = 0;
   exp_t   sb[$];
   rsa_modexp_ladder_if #(.WIDTH(8), .EXP_W(8)) bus ();
   rsa_modexp_ladder #(.WIDTH(8), .EXP_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask
   function automatic int ref_pow(int m, int e, int n);
      int r = 1 % n;
      int b = m;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = (r * b) % n;
         b = (b * b) % n;
      end
      return r;
   endfunction
   always @(negedge clk) if (bus.done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
         e = sb.pop_front();
         chk("result", bus.result, e.err ? 0 : e.res);
         chk("error", bus.error, e.err);
         chk("valid", bus.result_valid, !e.err);
         chk("latency", cyc, e.cyc);
         chk("busy_at_done", bus.busy, 0);
      end
   end
   task automatic issue(int m, int e, int n, bit push);
      exp_t x;
      @(posedge clk); #1;
      bus.message = 8'(m);
      bus.exponent = 8'(e);
      bus.modulus = 8'(n);
      bus.start = 1'b1;
      if (push) begin
         x.err = n < 2 || m >= n;
         x.res = x.err ? 0 : ref_pow(m, e, n);
         x.cyc = cyc + 1 + (x.err ? 2 : LAT);
         sb.push_back(x);
         n_want++;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask
   task automatic wait_idle();
      for (int i = 0; i < LAT + 20 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         chk("timeout", 1, 0);
         sb.delete();
      end
   endtask
   task automatic run(int m, int e, int n);
      issue(m, e, n, 1'b1);
      wait_idle();
   endtask
   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.message = '0;
      bus.modulus = '0;
      bus.exponent = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_error", bus.error, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_valid", bus.result_valid, 0);
      run(5, 3, 33);
      @(negedge clk);
      chk("hold_valid", bus.result_valid, 1);
      chk("hold_result", bus.result, 26);
      @(posedge clk); #1 bus.abort = 1'b1;
      @(posedge clk); #1 bus.abort = 1'b0;
      @(negedge clk);
      chk("idle_abort_valid", bus.result_valid, 0);
      chk("idle_abort_result", bus.result, 0);
      run(2, 8'hFF, 251);
      run(2, 8'h00, 251);
      run(40, 3, 1);
      run(40, 3, 33);
      @(posedge clk); #1 bus.start = 1'b1; bus.abort = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0; bus.abort = 1'b0;
      @(negedge clk);
      chk("abort_beats_start", bus.busy, 0);
      issue(5, 3, 33, 1'b0);
      repeat (49) @(posedge clk);
      #1 bus.abort = 1'b1;
      @(posedge clk); #1 bus.abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", bus.busy, 0);
      chk("abort_exp", dut.exp_q, 0);
      chk("abort_r0", dut.r0_q, 0);
      chk("abort_r1", dut.r1_q, 0);
      chk("abort_mm_acc", dut.u_mm.acc_q, 0);
      repeat (LAT + 5) @(negedge clk);
      run(5, 3, 33);
      issue(7, 5, 33, 1'b1);
      repeat (9) @(posedge clk);
      #1 bus.message = 8'd9; bus.exponent = 8'd2; bus.modulus = 8'd100; bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      wait_idle();
      repeat (LAT + 5) @(negedge clk);
      chk("no_queued_busy", bus.busy, 0);
      issue(11, 77, 201, 1'b0);
      repeat (69) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_done", bus.done, 0);
      chk("midrst_result", bus.result, 0);
      chk("midrst_valid", bus.result_valid, 0);
      chk("midrst_r0", dut.r0_q, 0);
      for (int v = 0; v < 300; v++) begin
         int n = (v % 16 == 15) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 255));
         int m = (v % 16 == 7) ? int'($urandom_range(n, 255)) : int'($urandom_range(0, n > 0 ? n - 1 : 0));
         run(m, int'($urandom_range(0, 255)), n);
      end
      repeat (4) @(negedge clk);
      chk("done_count", n_done, n_want);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
